cache_arbiter: RTL and testbench

//  Multiplexes the icache and dcache line-miss ports onto the single physical-memory port of the mp4 top.

---
 rtl/cache_arbiter_pkg.sv | 14 +
 rtl/cache_arbiter_stats.sv | 31 +++
 rtl/cache_arbiter.sv | 122 ++++++++++++
 tb/tb_cache_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the icache/dcache -> pmem line arbiter.
package arbiter_types;

  localparam int LINE_BYTES = 32;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic       {GRANT_I, GRANT_D}             arb_grant_t;

  // Saturating 32-bit increment used by the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/cache_arbiter_stats.sv
// Saturating activity counters for cache_arbiter; only built with ARBITER_STATS_EN.
`ifdef ARBITER_STATS_EN
module arbiter_stats
  import arbiter_types::*;
(
  input logic clk,
  input logic rst,
  input logic grant_i_i,
  input logic grant_d_i,
  input logic conflict_i,
  input logic busy_i
);

  logic [31:0] i_grants, d_grants, conflict_cycles, busy_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_grants        <= '0;
      d_grants        <= '0;
      conflict_cycles <= '0;
      busy_cycles     <= '0;
    end else begin
      i_grants        <= sat_inc(i_grants, grant_i_i);
      d_grants        <= sat_inc(d_grants, grant_d_i);
      conflict_cycles <= sat_inc(conflict_cycles, conflict_i);
      busy_cycles     <= sat_inc(busy_cycles, busy_i);
    end
  end

endmodule
`endif

// File: rtl/cache_arbiter.sv
// Round-robin arbiter placing icache and dcache line misses on one pmem port.
// Optional ARBITER_STATS_EN adds the arbiter_stats counter block.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = LINE_BYTES * 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  arb_state_t        state_q, state_d;
  arb_grant_t        last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req;
  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // last_q starts at GRANT_D so the icache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_D;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req && (!d_req || last_q == GRANT_D)) begin
          state_d = SERVE_I;
          wr_d    = 1'b0;
          addr_d  = i_address;
          wdata_d = '0;
        end else if (d_req) begin
          state_d = SERVE_D;
          wr_d    = d_write;  // write wins if both are raised
          addr_d  = d_address;
          wdata_d = d_wdata;
        end
      end
      SERVE_I: if (pmem_resp) begin state_d = DONE; last_d = GRANT_I; end
      SERVE_D: if (pmem_resp) begin state_d = DONE; last_d = GRANT_D; end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    unique case (state_q)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = addr_q;
        i_resp       = pmem_resp;
        i_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      SERVE_D: begin
        pmem_read    = ~wr_q;
        pmem_write   = wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        d_resp       = pmem_resp;
        d_rdata      = pmem_resp ? pmem_rdata : '0;
      end
      default: ;
    endcase
  end

`ifdef ARBITER_STATS_EN
  arbiter_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .grant_i_i  (state_q == IDLE && state_d == SERVE_I),
    .grant_d_i  (state_q == IDLE && state_d == SERVE_D),
    .conflict_i ((state_q == SERVE_I && d_req) || (state_q == SERVE_D && i_req)),
    .busy_i     (state_q != IDLE)
  );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single requests, ties, stability, reset abort.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic [AW-1:0] pmem_address;

  int n_cmp = 0;
  int n_err = 0;

  logic [LW-1:0] A5, DEAD, R1, R2, R3, W7;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".pmem_read"},  LW'(pmem_read),    '0);
    chk({tag, ".pmem_write"}, LW'(pmem_write),   '0);
    chk({tag, ".pmem_addr"},  LW'(pmem_address), '0);
    chk({tag, ".i_resp"},     LW'(i_resp),       '0);
    chk({tag, ".d_resp"},     LW'(d_resp),       '0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    A5   = {8{32'hA5A5A5A5}};
    DEAD = {8{32'hDEADBEEF}};
    R1   = {8{32'h11112222}};
    R2   = {8{32'h33334444}};
    R3   = {8{32'h55556666}};
    W7   = {8{32'h77778888}};
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    tick(); tick();
    chk_quiet("reset");
    chk("reset.i_rdata", i_rdata, '0);
    chk("reset.pmem_wdata", pmem_wdata, '0);
    rst = 1'b0;

    // 1: lone icache read
    tick();
    i_read = 1; i_address = 32'h60; #1;
    chk("t1.idle_read", LW'(pmem_read), '0);
    tick();
    chk("t1.pmem_read", LW'(pmem_read), 1);
    chk("t1.pmem_addr", LW'(pmem_address), LW'(32'h60));
    chk("t1.i_resp_pre", LW'(i_resp), '0);
    pmem_resp = 1; pmem_rdata = A5; #1;
    chk("t1.i_resp", LW'(i_resp), 1);
    chk("t1.i_rdata", i_rdata, A5);
    chk("t1.d_resp", LW'(d_resp), '0);
    chk("t1.d_rdata", d_rdata, '0);
    tick();
    pmem_resp = 0; i_read = 0; #1;
    chk_quiet("t1.done");
    tick();

    // 2: dcache write-back with 5-cycle memory latency
    d_write = 1; d_address = 32'h1000; d_wdata = DEAD;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2.pmem_write", LW'(pmem_write), 1);
      chk("t2.pmem_read", LW'(pmem_read), '0);
      chk("t2.pmem_addr", LW'(pmem_address), LW'(32'h1000));
      chk("t2.pmem_wdata", pmem_wdata, DEAD);
      if (k == 4) begin
        pmem_resp = 1; pmem_rdata = R1; #1;
        chk("t2.d_resp", LW'(d_resp), 1);
        chk("t2.i_resp", LW'(i_resp), '0);
      end else begin
        chk("t2.d_resp_wait", LW'(d_resp), '0);
      end
    end
    tick();
    pmem_resp = 0; d_write = 0; #1;
    chk_quiet("t2.done");
    tick();
    chk_quiet("t2.idle");

    // 3: tie, icache first; icache re-requests, second tie goes to dcache
    i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
    tick();
    chk("t3.first_addr", LW'(pmem_address), LW'(32'h100));
    pmem_resp = 1; pmem_rdata = R1; #1;
    chk("t3.i_resp1", LW'(i_resp), 1);
    chk("t3.d_resp1", LW'(d_resp), '0);
    tick();
    pmem_resp = 0; i_address = 32'h140; #1;
    chk("t3.done1", LW'(pmem_read), '0);
    tick();
    chk("t3.idle1", LW'(pmem_read), '0);
    tick();
    chk("t3.second_read", LW'(pmem_read), 1);
    chk("t3.second_addr", LW'(pmem_address), LW'(32'h200));
    pmem_resp = 1; pmem_rdata = R2; #1;
    chk("t3.d_resp2", LW'(d_resp), 1);
    chk("t3.d_rdata2", d_rdata, R2);
    chk("t3.i_resp2", LW'(i_resp), '0);
    tick();
    pmem_resp = 0; d_read = 0;
    tick();
    tick();
    chk("t3.third_addr", LW'(pmem_address), LW'(32'h140));
    pmem_resp = 1; pmem_rdata = R3; #1;
    chk("t3.i_rdata3", i_rdata, R3);
    tick();
    pmem_resp = 0; i_read = 0;
    tick();

`ifdef ARBITER_STATS_EN
    chk("t6.i_grants", LW'(dut.u_stats.i_grants), LW'(3));
    chk("t6.d_grants", LW'(dut.u_stats.d_grants), LW'(2));
    chk("t6.conflict_nz", LW'(dut.u_stats.conflict_cycles != 0), LW'(1));
`endif

    // 4: requester inputs change mid SERVE_D
    d_read = 1; d_address = 32'h1000;
    tick();
    d_address = 32'h2000; d_write = 1; d_read = 0; #1;
    chk("t4.addr_hold", LW'(pmem_address), LW'(32'h1000));
    chk("t4.read_hold", LW'(pmem_read), 1);
    tick();
    chk("t4.addr_hold2", LW'(pmem_address), LW'(32'h1000));
    chk("t4.write_hold", LW'(pmem_write), '0);
    d_write = 0;
    pmem_resp = 1; #1;
    chk("t4.d_resp", LW'(d_resp), 1);
    tick();
    pmem_resp = 0;
    tick();

    // 5: reset abort during SERVE_I, then a fresh dcache read
    i_read = 1; i_address = 32'h300;
    tick();
    chk("t5.serving", LW'(pmem_read), 1);
    rst = 1;
    tick();
    rst = 0; i_read = 0; #1;
    chk_quiet("t5.aborted");
    d_read = 1; d_address = 32'h400;
    tick();
    chk("t5.fresh_addr", LW'(pmem_address), LW'(32'h400));
    pmem_resp = 1; pmem_rdata = R1; #1;
    chk("t5.fresh_resp", LW'(d_resp), 1);
    chk("t5.no_i_resp", LW'(i_resp), '0);
    tick();
    pmem_resp = 0; d_read = 0;
    tick();

    // stray pmem_resp in IDLE, then d_read+d_write together
    pmem_resp = 1; pmem_rdata = R2; #1;
    chk("stray.i_resp", LW'(i_resp), '0);
    chk("stray.d_resp", LW'(d_resp), '0);
    chk("stray.d_rdata", d_rdata, '0);
    pmem_resp = 0;
    d_read = 1; d_write = 1; d_address = 32'h500; d_wdata = W7;
    tick();
    chk("both.write", LW'(pmem_write), 1);
    chk("both.read", LW'(pmem_read), '0);
    chk("both.wdata", pmem_wdata, W7);
    pmem_resp = 1; #1;
    chk("both.d_resp", LW'(d_resp), 1);
    tick();
    pmem_resp = 0; d_read = 0; d_write = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
